// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: register-file geometry and the MEM/WB write-back bundle.
package cpu_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 0;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

    typedef struct packed {
        logic      RegWrite;
        logic      MemtoReg;
        word_t     Read_Data;
        word_t     ALU_Result;
        reg_addr_t Write_Addr;
    } wb_bundle_t;

endpackage

// File: rtl/wb_register_file_if.sv
// MEM/WB write-back bundle plus the ID-stage read ports of the register file.
interface wb_register_file_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
);
    logic              RegWrite_in;
    logic              MemtoReg_in;
    logic [DATA_W-1:0] Read_Data_in;
    logic [DATA_W-1:0] ALU_Result_in;
    logic [ADDR_W-1:0] Write_Addr_in;
    logic [ADDR_W-1:0] Read_Addr1;
    logic [ADDR_W-1:0] Read_Addr2;
    logic [DATA_W-1:0] Read_Data1;
    logic [DATA_W-1:0] Read_Data2;
    logic [DATA_W-1:0] WB_Data;
    logic [15:0]       Write_Count;

    modport master (
        output RegWrite_in, MemtoReg_in, Read_Data_in, ALU_Result_in, Write_Addr_in,
        output Read_Addr1, Read_Addr2,
        input  Read_Data1, Read_Data2, WB_Data, Write_Count
    );

    modport slave (
        input  RegWrite_in, MemtoReg_in, Read_Data_in, ALU_Result_in, Write_Addr_in,
        input  Read_Addr1, Read_Addr2,
        output Read_Data1, Read_Data2, WB_Data, Write_Count
    );
endinterface

// File: rtl/wb_register_file_wb_mux.sv
// Write-back select: load data or ALU result, chosen by MemtoReg.
module wb_mux #(
    parameter int DATA_W = 32
) (
    input  logic              sel,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] alu_data,
    output logic [DATA_W-1:0] wb_data
);
    assign wb_data = sel ? mem_data : alu_data;
endmodule

// File: rtl/wb_register_file.sv
// Write-back stage register file: commit, two async read ports, saturating write counter.
// Optional REGFILE_BYPASS_EN: write-first forwarding of the in-flight write to the read ports.
module wb_register_file
    import cpu_pkg::*;
#(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int ZERO_REG = cpu_pkg::ZERO_REG
) (
    input  logic               clk,
    input  logic               rst,
    wb_register_file_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DATA_W-1:0] wb_data;
    logic [15:0]       write_count;
    logic              wr_en;

    wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
        .sel      (bus.MemtoReg_in),
        .mem_data (bus.Read_Data_in),
        .alu_data (bus.ALU_Result_in),
        .wb_data  (wb_data)
    );

    assign wr_en = bus.RegWrite_in && (bus.Write_Addr_in != ZERO_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            write_count <= '0;
        end else if (wr_en) begin
            regs[bus.Write_Addr_in] <= wb_data;
            if (write_count != 16'hFFFF) write_count <= write_count + 16'd1;
        end
    end

    // Zero register is forced at the read mux so it never depends on array contents.
    always_comb begin
        bus.Read_Data1 = (bus.Read_Addr1 == ZERO_ADDR) ? '0 : regs[bus.Read_Addr1];
        bus.Read_Data2 = (bus.Read_Addr2 == ZERO_ADDR) ? '0 : regs[bus.Read_Addr2];
`ifdef REGFILE_BYPASS_EN
        if (!rst && wr_en && bus.Write_Addr_in == bus.Read_Addr1) bus.Read_Data1 = wb_data;
        if (!rst && wr_en && bus.Write_Addr_in == bus.Read_Addr2) bus.Read_Data2 = wb_data;
`endif
    end

    assign bus.WB_Data     = wb_data;
    assign bus.Write_Count = write_count;

endmodule

// File: tb/tb_wb_register_file.sv
// Randomized bench for wb_register_file against an array-based reference model.
module tb_wb_register_file;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_register_file_if bus ();

    wb_register_file dut (.clk(clk), .rst(rst), .bus(bus));

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [31:0] ref_regs [32];
    int unsigned ref_cnt;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a, input logic [31:0] wb);
        if (a == 0) return 32'h0;
        if (BYPASS && !rst && bus.RegWrite_in && bus.Write_Addr_in != 0 && bus.Write_Addr_in == a)
            return wb;
        return ref_regs[a];
    endfunction

    task automatic drive(input logic we, input logic m2r, input logic [31:0] rd,
                         input logic [31:0] alu, input logic [4:0] wa,
                         input logic [4:0] ra1, input logic [4:0] ra2);
        bus.RegWrite_in   = we;
        bus.MemtoReg_in   = m2r;
        bus.Read_Data_in  = rd;
        bus.ALU_Result_in = alu;
        bus.Write_Addr_in = wa;
        bus.Read_Addr1    = ra1;
        bus.Read_Addr2    = ra2;
    endtask

    // Check combinational outputs mid-cycle, then advance the model across the edge.
    task automatic cycle(input string tag);
        logic [31:0] wb;
        @(negedge clk);
        wb = bus.MemtoReg_in ? bus.Read_Data_in : bus.ALU_Result_in;
        chk({tag, ".wb"},  bus.WB_Data, wb);
        chk({tag, ".rd1"}, bus.Read_Data1, exp_read(bus.Read_Addr1, wb));
        chk({tag, ".rd2"}, bus.Read_Data2, exp_read(bus.Read_Addr2, wb));
        chk({tag, ".cnt"}, {16'h0, bus.Write_Count}, ref_cnt);
        @(posedge clk);
        if (rst) begin
            foreach (ref_regs[i]) ref_regs[i] = 32'h0;
            ref_cnt = 0;
        end else if (bus.RegWrite_in && bus.Write_Addr_in != 0) begin
            ref_regs[bus.Write_Addr_in] = wb;
            if (ref_cnt < 32'hFFFF) ref_cnt++;
        end
        #1;
    endtask

    initial begin
        foreach (ref_regs[i]) ref_regs[i] = 32'h0;
        ref_cnt = 0;
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Every address reads zero after reset.
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
            cycle("rst_read");
        end

        // ALU path to r5, then read back.
        drive(1, 0, 32'h0, 32'h1234_5678, 5, 0, 0);
        cycle("alu_wr");
        drive(0, 0, 0, 0, 0, 5, 5);
        cycle("alu_rd");

        // Memory path to r31.
        drive(1, 1, 32'hDEAD_BEEF, 32'h1, 31, 0, 0);
        cycle("mem_wr");
        drive(0, 0, 0, 0, 0, 31, 5);
        cycle("mem_rd");

        // Zero register write is dropped.
        drive(1, 0, 32'h0, 32'hFFFF_FFFF, 0, 0, 0);
        cycle("zero_wr");
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle("zero_rd");

        // Same-cycle read of the write target.
        drive(1, 0, 0, 32'hA, 7, 0, 0);
        cycle("r7_a");
        drive(1, 0, 0, 32'hB, 7, 7, 7);
        cycle("r7_b_same");
        drive(0, 0, 0, 0, 0, 7, 7);
        cycle("r7_b_next");

        // Reset collides with a write; next write lands.
        rst = 1'b1;
        drive(1, 0, 0, 32'h55, 3, 3, 3);
        cycle("rst_coll");
        rst = 1'b0;
        drive(1, 0, 0, 32'h66, 3, 3, 0);
        cycle("post_rst_wr");
        drive(0, 0, 0, 0, 0, 3, 3);
        cycle("post_rst_rd");

        // Random traffic with occasional reset and biased read/write address overlap.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa;
            wa = 5'($urandom_range(0, 31));
            rst = ($urandom_range(0, 39) == 0);
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, wa,
                  ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)));
            cycle("rand");
        end
        rst = 1'b0;

        // Drive the counter past saturation without per-cycle checks.
        for (int n = 0; n < 65600; n++) begin
            drive(1, 0, 0, n, 9, 0, 0);
            @(posedge clk); #1;
            ref_regs[9] = n;
            if (ref_cnt < 32'hFFFF) ref_cnt++;
        end
        drive(1, 1, 32'hCAFE_F00D, 0, 12, 9, 12);
        cycle("sat_wr");
        drive(0, 0, 0, 0, 0, 12, 9);
        cycle("sat_rd");
        chk("sat_cnt", {16'h0, bus.Write_Count}, 32'h0000_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
